// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: command controller between spi_slave and the board LEDs.
// Captures each decoded SPI frame (cmd/addr/payload) during a chip-select
// transaction and executes it once cs returns high. Writes set per-LED
// brightness (0..100 %) that drives a PWM generator; reads arm a 24-bit
// response frame and raise the slave's transmit enable for the next
// transaction.
//
// Ports:
//   sysclk        system clock
//   rst           asynchronous active-high reset
//   cs            SPI chip select from pin, active-low, asynchronous
//   i_cmd         decoded command byte from spi_slave
//   i_addr        decoded address byte from spi_slave
//   i_payload     decoded payload byte from spi_slave
//   o_slv_tx_enb  transmit enable to spi_slave
//   o_slv_frame   response frame to spi_slave, {cmd, addr, payload}
//   o_led         PWM LED drive, active-high
//   o_err         one-cycle pulse on an invalid command or address
module spi_led_ctrl #(
   parameter int         NUM_LEDS = 4,
   parameter int         PWM_DIV  = 1250,
   parameter logic [7:0] CMD_NOP  = 8'h00,
   parameter logic [7:0] CMD_WR   = 8'h01,
   parameter logic [7:0] CMD_RD   = 8'h02,
   parameter logic [7:0] CMD_ERR  = 8'hEE
) (
   input  logic                sysclk,
   input  logic                rst,
   input  logic                cs,
   input  logic [7:0]          i_cmd,
   input  logic [7:0]          i_addr,
   input  logic [7:0]          i_payload,
   output logic                o_slv_tx_enb,
   output logic [23:0]         o_slv_frame,
   output logic [NUM_LEDS-1:0] o_led,
   output logic                o_err
);

   localparam int         IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int         PRE_W      = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam logic [7:0] NUM_LEDS_B = 8'(NUM_LEDS);
   localparam logic [6:0] PWM_TOP    = 7'd99;

   typedef enum logic [2:0] {IDLE, RX, EXEC, ARMED, TX} state_t;

   state_t state, state_next;

   // cs synchronizer; flops reset to 1 so reset looks like cs deasserted
   logic cs_meta, cs_sync, cs_prev;
   logic cs_fall, cs_rise;

   logic [7:0] cap_cmd, cap_addr, cap_payload;
   logic       capture_active;

   logic [6:0] duty        [NUM_LEDS];
   logic [6:0] active_duty [NUM_LEDS];

   logic             addr_ok;
   logic [IDX_W-1:0] idx;
   logic             wr_en, rd_ok, rd_bad, err_set;

   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [6:0]       pwm_cnt;

   // ------------------------------------------------------------------
   // cs synchronizer and edge detection
   // ------------------------------------------------------------------
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         cs_meta <= 1'b1;
         cs_sync <= 1'b1;
         cs_prev <= 1'b1;
      end else begin
         cs_meta <= cs;
         cs_sync <= cs_meta;
         cs_prev <= cs_sync;
      end
   end

   assign cs_fall = !cs_sync &&  cs_prev;
   assign cs_rise =  cs_sync && !cs_prev;

   // ------------------------------------------------------------------
   // Frame capture: NOP values from an idle slave never overwrite it
   // ------------------------------------------------------------------
   assign capture_active = (state == RX) || (state == TX);

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         cap_cmd     <= '0;
         cap_addr    <= '0;
         cap_payload <= '0;
      end else if (cs_fall) begin
         cap_cmd     <= '0;
         cap_addr    <= '0;
         cap_payload <= '0;
      end else if (capture_active && (i_cmd != CMD_NOP)) begin
         cap_cmd     <= i_cmd;
         cap_addr    <= i_addr;
         cap_payload <= i_payload;
      end
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   assign addr_ok = (cap_addr < NUM_LEDS_B);
   assign idx     = cap_addr[IDX_W-1:0];

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      rd_ok      = 1'b0;
      rd_bad     = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE:  if (cs_fall) state_next = RX;
         RX:    if (cs_rise) state_next = EXEC;
         EXEC: begin
            case (cap_cmd)
               CMD_NOP: ;
               CMD_WR: begin
                  if (addr_ok) wr_en   = 1'b1;
                  else         err_set = 1'b1;
               end
               CMD_RD: begin
                  if (addr_ok) rd_ok = 1'b1;
                  else begin
                     rd_bad  = 1'b1;
                     err_set = 1'b1;
                  end
               end
               default: err_set = 1'b1;
            endcase
            // cs may already be low again if the next transaction began
            // during EXEC; skip the waiting state in that case
            if (rd_ok || rd_bad) state_next = cs_sync ? ARMED : TX;
            else                 state_next = cs_sync ? IDLE  : RX;
         end
         ARMED: if (cs_fall) state_next = TX;
         TX:    if (cs_rise) state_next = EXEC;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Command execution registers
   // ------------------------------------------------------------------
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
         o_slv_frame  <= '0;
         o_slv_tx_enb <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         if (wr_en)
            duty[idx] <= (cap_payload > 8'd100) ? 7'd100 : cap_payload[6:0];
         if (rd_ok)
            o_slv_frame <= {CMD_RD, cap_addr, 1'b0, duty[idx]};
         else if (rd_bad)
            o_slv_frame <= {CMD_ERR, cap_addr, 8'hFF};
         o_slv_tx_enb <= (state_next == ARMED) || (state_next == TX);
         o_err        <= err_set;
      end
   end

   // ------------------------------------------------------------------
   // PWM generator
   // ------------------------------------------------------------------
   assign tick = (pre == PRE_W'(PWM_DIV - 1));

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         pre     <= '0;
         pwm_cnt <= '0;
         for (int unsigned i = 0; i < NUM_LEDS; i++) active_duty[i] <= '0;
      end else begin
         pre <= tick ? '0 : pre + PRE_W'(1);
         if (tick) begin
            if (pwm_cnt == PWM_TOP) begin
               pwm_cnt <= '0;
               // new duty only takes effect at a period boundary
               for (int unsigned i = 0; i < NUM_LEDS; i++) active_duty[i] <= duty[i];
            end else begin
               pwm_cnt <= pwm_cnt + 7'd1;
            end
         end
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         o_led <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_LEDS; i++) o_led[i] <= (pwm_cnt < active_duty[i]);
      end
   end

endmodule

// File: doc/spi_led_ctrl.md
# spi_led_ctrl

Command controller between `spi_slave` and the board LEDs. It captures each decoded SPI frame (cmd/addr/payload) at the end of a chip-select transaction and executes it. Writes set per-LED brightness (0–100 %), which drives a PWM generator. Reads arm a 24-bit response frame and assert the slave's transmit enable for the next transaction.

## Interface
- NUM_LEDS, 4, number of LED channels (1–8)
- PWM_DIV, 1250, sysclk cycles per PWM tick; 100 ticks per period (1 kHz at 125 MHz)
- CMD_NOP, 8'h00, no-operation command
- CMD_WR, 8'h01, write brightness
- CMD_RD, 8'h02, read brightness
- CMD_ERR, 8'hEE, cmd field of an error response
---
- sysclk  in  1  system clock, 125 MHz
- rst  in  1  reset, asynchronous, active-high
- cs  in  1  SPI chip select straight from pin, active-low, asynchronous to sysclk
- i_cmd  in  8  `o_cmd` from spi_slave
- i_addr  in  8  `o_addr` from spi_slave
- i_payload  in  8  `o_payload` from spi_slave
- o_slv_tx_enb  out  1  to spi_slave `slv_tx_enb`
- o_slv_frame  out  24  to spi_slave `i_slv_frame`, {cmd, addr, payload}
- o_led  out  NUM_LEDS  PWM LED drive, active-high
- o_err  out  1  one-cycle pulse on an invalid command or address

## Operation
- cs passes through a 2-FF synchronizer (cs_sync) plus a previous-value register.
  - cs_fall = cs_sync low and prev high.
  - cs_rise = cs_sync high and prev low.
- Capture register {cap_cmd, cap_addr, cap_payload}:
  - Cleared to 0 on cs_fall.
  - Loaded every cycle in RX/TX when i_cmd != CMD_NOP.
  - NOP values (slave idle or cleared after cs high) never overwrite it.
- FSM states: IDLE, RX, EXEC, ARMED, TX.
  - IDLE: tx_enb 0. cs_fall → RX.
  - RX: capture active. cs_rise → EXEC.
  - EXEC: one cycle; decodes the capture register (rules below).
  - ARMED: tx_enb 1, frame held. cs_fall → TX.
  - TX: tx_enb 1, capture active (full duplex). cs_rise → EXEC, and tx_enb drops on the same edge.
- EXEC decode:
  - CMD_WR, addr < NUM_LEDS: duty[addr] ← min(payload, 100).
  - CMD_RD, addr < NUM_LEDS: o_slv_frame ← {CMD_RD, addr, duty[addr]}.
  - CMD_RD, addr ≥ NUM_LEDS: o_slv_frame ← {CMD_ERR, addr, 8'hFF}; o_err pulses.
  - CMD_WR, addr ≥ NUM_LEDS: no register change; o_err pulses.
  - Unknown cmd: o_err pulses, nothing else changes.
  - CMD_NOP (empty capture): no action, no err.
- EXEC next state:
  - Read executed (including error read) → ARMED if cs_sync high, TX if cs_sync already low.
  - Otherwise → IDLE if cs_sync high, RX if low.
- o_slv_frame changes only in EXEC. It is stable throughout ARMED/TX.
- PWM:
  - Prescaler counts 0..PWM_DIV-1; tick on wrap.
  - pwm_cnt counts 0..99 on ticks.
  - Per channel: active duty loads from duty[i] only when pwm_cnt wraps 99→0, so there are no glitched periods.
  - o_led[i] = (pwm_cnt < active_duty[i]), registered.
  - duty 0 → constantly low; 100 → constantly high.

## Timing
- Reset (async assert, sync release): state IDLE; o_slv_tx_enb 0; o_slv_frame 24'h0; o_led 0; o_err 0.
- Reset also clears all duty/active duty, the prescaler, pwm_cnt, the capture register and the synchronizer flops (sync flops reset to 1, i.e. cs deasserted).
- Write latency, counted from the first sysclk edge that samples cs high:
  - Edge 2: cs_sync high.
  - Edge 3: EXEC.
  - Edge 4: duty updated.
  - o_led reflects the new value from the next PWM period start.
- Read: o_slv_tx_enb and o_slv_frame are valid on edge 4 as above. They hold until the cs_rise that ends the following transaction; tx_enb is low one edge after that.
- Reset mid-transaction: everything returns to reset values immediately. A transaction in progress is discarded; the first cs_fall after release starts a fresh RX.
- cs glitch high for < 2 sysclk may be missed. This is legal: the transaction is then treated as continuing.
- o_err is high exactly one cycle (the edge after EXEC).

## Test plan
- Reset release, no cs activity for 3 PWM periods → o_led 0, o_slv_tx_enb 0, o_slv_frame 0, o_err never 1.
- Frame {01,02,32} (LED2 50 %) → duty[2]=50 on edge 4; o_led[2] high exactly 50 of 100 ticks from the next period; other LEDs stay 0.
- Write {01,01,C8} (200 %) then read {02,01,xx} → o_led[1] constantly high. After the read, tx_enb=1 and frame 24'h020164, held through the next transaction; tx_enb drops after its cs_rise.
- Read {02,07,00} with NUM_LEDS=4 → o_err one-cycle pulse; frame 24'hEE07FF; tx_enb=1.
- Write {05,00,10} → o_err pulse, duty unchanged.
- Full-duplex: armed read of LED0, next transaction carries {01,00,0A} → response frame stays stable during TX; after its cs_rise, duty[0]=10 and tx_enb=0.
- Assert rst while in ARMED → tx_enb and frame clear asynchronously; all duties 0.
